// File: rtl/bp_pkg.sv
// Shared types for the branch predictor: counter encodings, FSM state and
// the table entry layout.
package bp_pkg;

  localparam logic [1:0] STRONG_NT = 2'b00;
  localparam logic [1:0] WEAK_NT   = 2'b01;
  localparam logic [1:0] WEAK_T    = 2'b10;
  localparam logic [1:0] STRONG_T  = 2'b11;
  localparam logic [1:0] RESET_CTR = WEAK_NT;

  typedef enum logic {
    IDLE     = 1'b0,
    REDIRECT = 1'b1
  } bp_state_e;

  // Tag is sized for the smallest table; unused upper bits stay zero.
  typedef struct packed {
    logic        valid;
    logic [29:0] tag;
    logic [31:0] target;
    logic [1:0]  ctr;
  } bp_entry_t;

  function automatic logic [1:0] ctr_next(
    input logic [1:0] c,
    input logic       taken
  );
    logic [1:0] n;
    n = c;
    if (taken && c != STRONG_T)
      n = c + 2'd1;
    else if (!taken && c != STRONG_NT)
      n = c - 2'd1;
    return n;
  endfunction

endpackage

// File: rtl/bp_table.sv
// Direct-mapped prediction table: combinational read port for fetch and a
// single update port for resolving branches.
module bp_table
  import bp_pkg::*;
#(
  parameter int INDEX_BITS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] rd_pc_i,
  output logic        rd_taken_o,
  output logic [31:0] rd_target_o,
  input  logic        upd_en_i,
  input  logic [31:2] upd_pc_i,
  input  logic        upd_taken_i,
  input  logic [31:0] upd_target_i
);

  localparam int N = 1 << INDEX_BITS;

  bp_entry_t tbl_q [N];

  logic [INDEX_BITS-1:0] rd_idx;
  logic [INDEX_BITS-1:0] upd_idx;
  logic [29:0]           rd_tag;
  logic [29:0]           upd_tag;
  bp_entry_t             rd_e;
  bp_entry_t             upd_e;
  logic                  upd_hit;
  logic                  wr_en;
  bp_entry_t             wr_e;

  assign rd_idx  = rd_pc_i[INDEX_BITS+1:2];
  assign upd_idx = upd_pc_i[INDEX_BITS+1:2];
  assign rd_tag  = 30'(rd_pc_i[31:INDEX_BITS+2]);
  assign upd_tag = 30'(upd_pc_i[31:INDEX_BITS+2]);
  assign rd_e    = tbl_q[rd_idx];
  assign upd_e   = tbl_q[upd_idx];

  // Reads see the registered table, so same-index updates show next cycle.
  assign rd_taken_o  = rd_e.valid && (rd_e.tag == rd_tag) && rd_e.ctr[1];
  assign rd_target_o = rd_taken_o ? rd_e.target : rd_pc_i + 32'd4;

  assign upd_hit = upd_e.valid && (upd_e.tag == upd_tag);

  always_comb begin
    wr_en = 1'b0;
    wr_e  = upd_e;
    if (upd_en_i) begin
      if (upd_hit) begin
        wr_en    = 1'b1;
        wr_e.ctr = ctr_next(upd_e.ctr, upd_taken_i);
        if (upd_taken_i)
          wr_e.target = upd_target_i;
      end else if (upd_taken_i) begin
        wr_en       = 1'b1;
        wr_e.valid  = 1'b1;
        wr_e.tag    = upd_tag;
        wr_e.target = upd_target_i;
        wr_e.ctr    = WEAK_T;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        tbl_q[i].valid  <= 1'b0;
        tbl_q[i].tag    <= '0;
        tbl_q[i].target <= '0;
        tbl_q[i].ctr    <= RESET_CTR;
      end
    end else if (wr_en) begin
      tbl_q[upd_idx] <= wr_e;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Branch predictor top: mispredict detection, one-cycle redirect FSM and
// optional perf counters (enabled by BP_PERF_CNT_EN).
module branch_predictor
  import bp_pkg::*;
#(
  parameter int INDEX_BITS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] if_pc,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        ex_valid,
  input  logic [31:0] ex_pc,
  input  logic        ex_taken,
  input  logic [31:0] ex_target,
  input  logic        ex_pred_taken,
  input  logic [31:0] ex_pred_target,
  output logic        redirect,
  output logic [31:0] redirect_pc
`ifdef BP_PERF_CNT_EN
  ,
  output logic [31:0] perf_branches,
  output logic [31:0] perf_mispredicts
`endif
);

  bp_state_e   state_q, state_d;
  logic [31:0] rpc_q, rpc_d;
  logic        accept;
  logic        mispred;

  // The EX slot during REDIRECT is a delay slot or wrong-path; drop it.
  assign accept  = ex_valid && (state_q == IDLE);
  assign mispred = accept &&
                   ((ex_taken != ex_pred_taken) ||
                    (ex_taken && (ex_target != ex_pred_target)));

  bp_table #(
    .INDEX_BITS (INDEX_BITS)
  ) u_table (
    .clk          (clk),
    .rst          (rst),
    .rd_pc_i      (if_pc),
    .rd_taken_o   (pred_taken),
    .rd_target_o  (pred_target),
    .upd_en_i     (accept),
    .upd_pc_i     (ex_pc[31:2]),
    .upd_taken_i  (ex_taken),
    .upd_target_i (ex_target)
  );

  always_comb begin
    state_d = state_q;
    rpc_d   = rpc_q;
    unique case (state_q)
      IDLE: begin
        if (mispred) begin
          state_d = REDIRECT;
          rpc_d   = ex_taken ? ex_target : ex_pc + 32'd8;
        end
      end
      REDIRECT: state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rpc_q   <= '0;
    end else begin
      state_q <= state_d;
      rpc_q   <= rpc_d;
    end
  end

  assign redirect    = (state_q == REDIRECT);
  assign redirect_pc = rpc_q;

`ifdef BP_PERF_CNT_EN
  logic [31:0] br_q, mis_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      br_q  <= '0;
      mis_q <= '0;
    end else begin
      if (accept)
        br_q <= br_q + 32'd1;
      if (mispred)
        mis_q <= mis_q + 32'd1;
    end
  end

  assign perf_branches    = br_q;
  assign perf_mispredicts = mis_q;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed vector table, corner
// sequences and random traffic against a behavioural table model.
module tb_branch_predictor;

  localparam int NI = 4;
  localparam int NE = 1 << NI;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic        ex_taken;
  logic [31:0] ex_target;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_target;
  logic        redirect;
  logic [31:0] redirect_pc;
`ifdef BP_PERF_CNT_EN
  logic [31:0] perf_branches;
  logic [31:0] perf_mispredicts;
`endif

  branch_predictor #(.INDEX_BITS(NI)) dut (
    .clk            (clk),
    .rst            (rst),
    .if_pc          (if_pc),
    .pred_taken     (pred_taken),
    .pred_target    (pred_target),
    .ex_valid       (ex_valid),
    .ex_pc          (ex_pc),
    .ex_taken       (ex_taken),
    .ex_target      (ex_target),
    .ex_pred_taken  (ex_pred_taken),
    .ex_pred_target (ex_pred_target),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc)
`ifdef BP_PERF_CNT_EN
    ,
    .perf_branches    (perf_branches),
    .perf_mispredicts (perf_mispredicts)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] ipc;
    logic        ev;
    logic [31:0] epc;
    logic        et;
    logic [31:0] etg;
    logic        ept;
    logic [31:0] eptg;
    logic        xpt;
    logic [31:0] xtg;
    logic        xr;
    logic [31:0] xrpc;
  } vec_t;

  int checks = 0;
  int errors = 0;

  // Behavioural model: plain arrays and integer counters 0..3.
  bit          m_valid [NE];
  logic [31:0] m_tag   [NE];
  logic [31:0] m_tgt   [NE];
  int          m_ctr   [NE];
  bit          m_redir;
  logic [31:0] m_rpc;
  logic [31:0] m_br;
  logic [31:0] m_mis;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  function automatic void m_reset();
    for (int i = 0; i < NE; i++) begin
      m_valid[i] = 0;
      m_tag[i]   = 0;
      m_tgt[i]   = 0;
      m_ctr[i]   = 1;
    end
    m_redir = 0;
    m_rpc   = 0;
    m_br    = 0;
    m_mis   = 0;
  endfunction

  function automatic void m_pred(input logic [31:0] pc, output bit t,
                                 output logic [31:0] tg);
    int i;
    i  = int'((pc >> 2) % NE);
    t  = m_valid[i] && (m_tag[i] == (pc >> (NI + 2))) && (m_ctr[i] >= 2);
    tg = t ? m_tgt[i] : pc + 32'd4;
  endfunction

  function automatic void m_step(input vec_t t);
    bit mis;
    int i;
    bit hit;
    mis = 0;
    if (!m_redir && t.ev) begin
      m_br = m_br + 1;
      mis  = (t.et != t.ept) || (t.et && (t.etg != t.eptg));
      i    = int'((t.epc >> 2) % NE);
      hit  = m_valid[i] && (m_tag[i] == (t.epc >> (NI + 2)));
      if (hit) begin
        m_ctr[i] = t.et ? ((m_ctr[i] < 3) ? m_ctr[i] + 1 : 3)
                        : ((m_ctr[i] > 0) ? m_ctr[i] - 1 : 0);
        if (t.et) m_tgt[i] = t.etg;
      end else if (t.et) begin
        m_valid[i] = 1;
        m_tag[i]   = t.epc >> (NI + 2);
        m_tgt[i]   = t.etg;
        m_ctr[i]   = 2;
      end
      if (mis) begin
        m_mis = m_mis + 1;
        m_rpc = t.et ? t.etg : t.epc + 32'd8;
      end
    end
    m_redir = mis;
  endfunction

  // One cycle: drive, check against model (and vector if asked), clock.
  task automatic cyc(input vec_t t, input bit use_exp, input string nm);
    bit          mt;
    logic [31:0] mtg;
    if_pc          = t.ipc;
    ex_valid       = t.ev;
    ex_pc          = t.epc;
    ex_taken       = t.et;
    ex_target      = t.etg;
    ex_pred_taken  = t.ept;
    ex_pred_target = t.eptg;
    #1;
    m_pred(t.ipc, mt, mtg);
    chk({nm, ".m_pt"},   32'(pred_taken),  32'(mt));
    chk({nm, ".m_ptg"},  pred_target,      mtg);
    chk({nm, ".m_rd"},   32'(redirect),    32'(m_redir));
    chk({nm, ".m_rpc"},  redirect_pc,      m_rpc);
    if (use_exp) begin
      chk({nm, ".pt"},   32'(pred_taken),  32'(t.xpt));
      chk({nm, ".ptg"},  pred_target,      t.xtg);
      chk({nm, ".rd"},   32'(redirect),    32'(t.xr));
      chk({nm, ".rpc"},  redirect_pc,      t.xrpc);
    end
    @(posedge clk);
    m_step(t);
    #1;
  endtask

  function automatic vec_t mk(
    input logic [31:0] ipc, input logic ev, input logic [31:0] epc,
    input logic et, input logic [31:0] etg, input logic ept,
    input logic [31:0] eptg, input logic xpt, input logic [31:0] xtg,
    input logic xr, input logic [31:0] xrpc);
    vec_t v;
    v.ipc = ipc; v.ev = ev; v.epc = epc; v.et = et; v.etg = etg;
    v.ept = ept; v.eptg = eptg; v.xpt = xpt; v.xtg = xtg;
    v.xr = xr; v.xrpc = xrpc;
    return v;
  endfunction

  localparam logic [31:0] A  = 32'h0040_0010;
  localparam logic [31:0] A4 = 32'h0040_0014;
  localparam logic [31:0] A8 = 32'h0040_0018;
  localparam logic [31:0] T  = 32'h0040_0100;
  localparam logic [31:0] T2 = 32'h0040_0200;
  localparam logic [31:0] W  = 32'hFFFF_FFFC;

  vec_t vt[$];
  vec_t r;

  initial begin
    vt.push_back(mk(A, 0, 0, 0, 0, 0, 0,   0, A4, 0, 0));
    vt.push_back(mk(A, 1, A, 1, T, 0, A4,  0, A4, 0, 0));
    vt.push_back(mk(A, 0, 0, 0, 0, 0, 0,   1, T,  1, T));
    vt.push_back(mk(A, 1, A, 1, T, 1, T,   1, T,  0, T));
    vt.push_back(mk(A, 1, A, 1, T, 1, T,   1, T,  0, T));
    vt.push_back(mk(A, 1, A, 1, T, 1, T,   1, T,  0, T));
    vt.push_back(mk(A, 1, A, 0, T, 1, T,   1, T,  0, T));
    vt.push_back(mk(A, 0, 0, 0, 0, 0, 0,   1, T,  1, A8));
    vt.push_back(mk(A, 0, 0, 0, 0, 0, 0,   1, T,  0, A8));
    vt.push_back(mk(A, 1, A, 0, T, 1, T,   1, T,  0, A8));
    vt.push_back(mk(A, 0, 0, 0, 0, 0, 0,   0, A4, 1, A8));
    vt.push_back(mk(A, 1, A, 0, T, 0, A4,  0, A4, 0, A8));
    vt.push_back(mk(A, 1, A, 0, T, 0, A4,  0, A4, 0, A8));
    vt.push_back(mk(A, 1, A, 1, T, 0, A4,  0, A4, 0, A8));
    vt.push_back(mk(A, 0, 0, 0, 0, 0, 0,   0, A4, 1, T));
    vt.push_back(mk(W, 1, W, 0, 0, 1, 0,   0, 0,  0, T));
    vt.push_back(mk(W, 0, 0, 0, 0, 0, 0,   0, 0,  1, 32'h4));
    vt.push_back(mk(A, 1, A, 1, T, 0, A4,  0, A4, 0, 32'h4));
    vt.push_back(mk(A, 0, 0, 0, 0, 0, 0,   1, T,  1, T));
    vt.push_back(mk(A, 1, A, 1, T2, 1, T,  1, T,  0, T));
    vt.push_back(mk(A, 0, 0, 0, 0, 0, 0,   1, T2, 1, T2));

    rst = 1'b1;
    if_pc = 0; ex_valid = 0; ex_pc = 0; ex_taken = 0;
    ex_target = 0; ex_pred_taken = 0; ex_pred_target = 0;
    m_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    foreach (vt[i])
      cyc(vt[i], 1, $sformatf("vec%0d", i));

    // Second mispredict lands in the REDIRECT cycle and must be dropped.
    r = mk(32'h0040_0020, 1, 32'h0040_0020, 1, 32'h0040_0200, 0,
           32'h0040_0024, 0, 32'h0040_0024, 0, T2);
    cyc(r, 1, "drop.a");
    r = mk(32'h0040_0030, 1, 32'h0040_0030, 1, 32'h0040_0300, 0,
           32'h0040_0034, 0, 32'h0040_0034, 1, 32'h0040_0200);
    cyc(r, 1, "drop.b");
    r = mk(32'h0040_0030, 0, 0, 0, 0, 0, 0,
           0, 32'h0040_0034, 0, 32'h0040_0200);
    cyc(r, 1, "drop.c");
    r = mk(32'h0040_0020, 0, 0, 0, 0, 0, 0,
           1, 32'h0040_0200, 0, 32'h0040_0200);
    cyc(r, 1, "drop.d");

    for (int n = 0; n < 400; n++) begin
      r.ipc  = 32'h0040_0000 | (32'($urandom_range(0, 1)) << 8)
                             | (32'($urandom_range(0, 15)) << 2);
      r.ev   = ($urandom_range(0, 3) != 0);
      r.epc  = 32'h0040_0000 | (32'($urandom_range(0, 1)) << 8)
                             | (32'($urandom_range(0, 15)) << 2);
      r.et   = 1'($urandom_range(0, 1));
      r.etg  = 32'h0040_1000 | (32'($urandom_range(0, 3)) << 4);
      r.ept  = 1'($urandom_range(0, 1));
      r.eptg = ($urandom_range(0, 3) == 0) ? r.etg + 32'd16 : r.etg;
      cyc(r, 0, $sformatf("rnd%0d", n));
    end

`ifdef BP_PERF_CNT_EN
    chk("perf_br", perf_branches, m_br);
    chk("perf_mis", perf_mispredicts, m_mis);
`endif

    // Reset asserted in the middle of a REDIRECT cycle.
    r = mk(A, 1, A, 1, 32'h0040_0500, 0, A4, 0, 0, 0, 0);
    cyc(r, 0, "rst.a");
    ex_valid = 1'b0;
    #1;
    chk("rst.pre_rd", 32'(redirect), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst.rd", 32'(redirect), 32'd0);
    chk("rst.rpc", redirect_pc, 32'd0);
    chk("rst.pt", 32'(pred_taken), 32'd0);
`ifdef BP_PERF_CNT_EN
    chk("rst.perf_br", perf_branches, 32'd0);
    chk("rst.perf_mis", perf_mispredicts, 32'd0);
`endif
    m_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    r = mk(A, 0, 0, 0, 0, 0, 0, 0, A4, 0, 0);
    cyc(r, 1, "rst.b");
    cyc(r, 1, "rst.c");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL have parameter INDEX_BITS, default 4, meaning the table holds 2^INDEX_BITS direct-mapped entries.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port if_pc, input, 32, fetch-stage PC to be predicted.
REQ-005 SHALL have port pred_taken, output, 1, predicted taken for if_pc.
REQ-006 SHALL have port pred_target, output, 32, predicted next-fetch target.
REQ-007 SHALL have port ex_valid, input, 1, a conditional branch resolves in EX this cycle.
REQ-008 SHALL have ports ex_pc (input, 32), ex_taken (input, 1; branch decision from the take-branch logic) and ex_target (input, 32; computed branch target).
REQ-009 SHALL have ports ex_pred_taken (input, 1) and ex_pred_target (input, 32), the prediction carried down the pipe with the branch.
REQ-010 SHALL have ports redirect (output, 1; flush IF/ID and refetch) and redirect_pc (output, 32; refetch address).

Function
REQ-011 SHALL form index = pc[INDEX_BITS+1:2] and tag = pc[31:INDEX_BITS+2]; each entry holds valid, tag, target[31:0] and ctr[1:0].
REQ-012 SHALL drive pred_taken = valid & tag match & ctr[1], combinationally from if_pc with zero latency.
REQ-013 SHALL drive pred_target = entry target when pred_taken, else if_pc+4.
REQ-014 SHALL flag a mispredict when ex_valid and (ex_taken != ex_pred_taken, or ex_taken and ex_target != ex_pred_target).
REQ-015 SHALL implement FSM IDLE/REDIRECT: IDLE->REDIRECT on mispredict; REDIRECT->IDLE unconditionally after one cycle.
REQ-016 SHALL register the redirect, asserting redirect for exactly the one cycle in REDIRECT (one-cycle latency after the resolve edge).
REQ-017 SHALL set redirect_pc = ex_target if ex_taken, else ex_pc+8 (past the delay slot); redirect_pc holds its value in IDLE.
REQ-018 SHALL ignore ex_valid while in REDIRECT (no table update, no mispredict), because the EX instruction then is a delay slot or wrong-path.
REQ-019 SHALL, on ex_valid with a table hit, saturate-increment ctr if taken or saturate-decrement it if not taken, and write target if taken; ctr stays at 11 and at 00.
REQ-020 SHALL, on ex_valid with a miss, allocate on taken (valid=1, tag, target, ctr=10) and not allocate on not-taken.
REQ-021 SHALL, when the prediction read and the update hit the same index in one cycle, return the pre-update contents; the write is visible next cycle.
REQ-022 SHALL perform all address arithmetic modulo 2^32 (if_pc+4 and ex_pc+8 wrap).

Reset
REQ-023 SHALL, while rst=1, asynchronously clear all valid bits, set all ctr=01, set state=IDLE, redirect=0 and redirect_pc=0.
REQ-024 SHALL drop redirect immediately if rst asserts mid-REDIRECT, and start in IDLE after release.

Configuration
REQ-025 SHALL, with BP_PERF_CNT_EN defined, add outputs perf_branches[31:0] and perf_mispredicts[31:0], reset to 0, incrementing on each accepted ex_valid and each mispredict, wrapping at 2^32.
REQ-026 SHALL, without BP_PERF_CNT_EN, have neither those ports nor any counter logic; all other behaviour is identical.

Structure
REQ-027 SHALL place in shared package bp_pkg: ctr encodings (STRONG_NT=00, WEAK_NT=01, WEAK_T=10, STRONG_T=11), RESET_CTR=WEAK_NT, the FSM state enum and the entry struct typedef.
REQ-028 SHALL implement storage plus read/update logic in one sub-module, bp_table; branch_predictor holds the FSM, the mispredict compare and the counters.

Verification
REQ-029 Reset, then if_pc=0x00400010 -> pred_taken=0, pred_target=0x00400014, redirect=0.
REQ-030 Resolve ex_pc=0x00400010, ex_taken=1, ex_target=0x00400100, pred=0 -> redirect=1 for one cycle next cycle, redirect_pc=0x00400100; then if_pc=0x00400010 -> pred_taken=1, target 0x00400100.
REQ-031 Same branch taken 3 more times, then not-taken with pred=1 -> ctr reaches 11, stays 11, drops to 10; redirect_pc=0x00400018; next prediction still taken.
REQ-032 Mispredict followed by ex_valid mispredict in the REDIRECT cycle -> second is ignored: one redirect pulse, table unchanged by the second.
REQ-033 Update and fetch to the same index in one cycle -> prediction reflects old entry; new entry visible next cycle.
REQ-034 Assert rst during the REDIRECT cycle -> redirect=0 at once, table invalid; with BP_PERF_CNT_EN both counters read 0.
